// File: rtl/ad80305_rx_deframer_mc.sv
// Receive deframer for an AD80305-style DDR IQ interface: aligns to FRAME, qualifies lock over
// whole periods and publishes all channels' I/Q samples together once per good locked period.
module ad80305_rx_deframer_mc #(
  parameter int unsigned LANE_W       = 6,
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned UNLOCK_ERRS  = 3
) (
  input  logic                         i_rx_clk_p,
  input  logic                         i_fpga_rst_125p,
  input  logic                         i_frame_h,
  input  logic                         i_frame_l,
  input  logic [LANE_W-1:0]            i_data_h,
  input  logic [LANE_W-1:0]            i_data_l,
  input  logic                         i_err_clr,
  output logic                         o_iq_vld,
  output logic [NUM_CH*2*LANE_W-1:0]   o_idata,
  output logic [NUM_CH*2*LANE_W-1:0]   o_qdata,
  output logic                         o_locked,
  output logic [15:0]                  o_err_cnt,
  output logic [1:0]                   o_state
);

  localparam int unsigned SW = 2 * LANE_W;
  localparam int unsigned DW = NUM_CH * SW;
  localparam int unsigned P  = 2 * NUM_CH;
  localparam int unsigned PW = $clog2(P);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            frame_h_q;
  logic            bad_q, bad_d;
  logic [3:0]      good_cnt_q, good_cnt_d;
  logic [3:0]      bad_cnt_q, bad_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [DW-1:0]   ish_q, ish_d, qsh_q, qsh_d;
  logic [DW-1:0]   idata_q, idata_d, qdata_q, qdata_d;
  logic            vld_q, vld_d;

  logic detect, active, exp_frame, mismatch, last, period_bad, emit;

  // The detecting cycle in HUNT is itself phase 0, so it takes part in the first period.
  always_comb begin
    detect     = (state_q == StHunt) && i_frame_h && !frame_h_q;
    active     = (state_q != StHunt) || detect;
    exp_frame  = (phase_q < PW'(NUM_CH));
    mismatch   = (i_frame_h != i_frame_l) || (i_frame_h != exp_frame);
    last       = active && (phase_q == PW'(P - 1));
    period_bad = bad_q || mismatch;
    emit       = (state_q == StLocked) && last && !period_bad;
  end

  always_ff @(posedge i_rx_clk_p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StHunt: begin
        if (detect) state_d = StCheck;
      end
      StCheck: begin
        if (last) begin
          if (period_bad) begin
            state_d = StHunt;
          end else if (good_cnt_q == 4'(LOCK_PERIODS - 1)) begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (last && period_bad && (bad_cnt_q == 4'(UNLOCK_ERRS - 1))) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    o_state   = state_q;
    o_locked  = (state_q == StLocked);
    o_iq_vld  = vld_q;
    o_idata   = idata_q;
    o_qdata   = qdata_q;
    o_err_cnt = err_cnt_q;
  end

  // Phase k carries channel k/2; even phases carry the upper half of each sample.
  always_comb begin
    ish_d = ish_q;
    qsh_d = qsh_q;
    for (int unsigned k = 0; k < P; k++) begin
      if (active && (phase_q == PW'(k))) begin
        ish_d[(k / 2) * SW + ((k % 2 == 0) ? LANE_W : 0) +: LANE_W] = i_data_l;
        qsh_d[(k / 2) * SW + ((k % 2 == 0) ? LANE_W : 0) +: LANE_W] = i_data_h;
      end
    end
  end

  always_comb begin
    phase_d    = (active && !last) ? phase_q + 1'b1 : '0;
    bad_d      = active && !last && period_bad;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (detect) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if ((state_q == StCheck) && last && !period_bad) begin
      good_cnt_d = good_cnt_q + 4'd1;
    end else if ((state_q == StLocked) && last) begin
      bad_cnt_d = (!period_bad || (state_d == StHunt)) ? 4'd0 : bad_cnt_q + 4'd1;
    end

    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (last && period_bad && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    vld_d   = emit;
    idata_d = emit ? ish_d : idata_q;
    qdata_d = emit ? qsh_d : qdata_q;
  end

  always_ff @(posedge i_rx_clk_p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      phase_q    <= '0;
      frame_h_q  <= 1'b0;
      bad_q      <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ish_q      <= '0;
      qsh_q      <= '0;
      idata_q    <= '0;
      qdata_q    <= '0;
      vld_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      frame_h_q  <= i_frame_h;
      bad_q      <= bad_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ish_q      <= ish_d;
      qsh_q      <= qsh_d;
      idata_q    <= idata_d;
      qdata_q    <= qdata_d;
      vld_q      <= vld_d;
    end
  end

endmodule

// File: tb/tb_ad80305_rx_deframer_mc.sv
// Bench for ad80305_rx_deframer_mc: a period-level model checks the 1-channel instance every
// cycle; directed literal checks pin the model and the 2-channel instance.
module tb_ad80305_rx_deframer_mc;

  localparam int unsigned P1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fh, fl, clr;
  logic [5:0]  dh, dl;
  logic        vld1, lk1;
  logic [11:0] id1, qd1;
  logic [15:0] ec1;
  logic [1:0]  st1;

  logic        f2;
  logic [5:0]  d2h, d2l;
  logic        vld2, lk2;
  logic [23:0] id2, qd2;
  logic [15:0] ec2;
  logic [1:0]  st2;

  ad80305_rx_deframer_mc #(.LANE_W(6), .NUM_CH(1)) dut1 (
    .i_rx_clk_p(clk), .i_fpga_rst_125p(rst_n), .i_frame_h(fh), .i_frame_l(fl),
    .i_data_h(dh), .i_data_l(dl), .i_err_clr(clr), .o_iq_vld(vld1), .o_idata(id1),
    .o_qdata(qd1), .o_locked(lk1), .o_err_cnt(ec1), .o_state(st1)
  );

  ad80305_rx_deframer_mc #(.LANE_W(6), .NUM_CH(2)) dut2 (
    .i_rx_clk_p(clk), .i_fpga_rst_125p(rst_n), .i_frame_h(f2), .i_frame_l(f2),
    .i_data_h(d2h), .i_data_l(d2l), .i_err_clr(1'b0), .o_iq_vld(vld2), .o_idata(id2),
    .o_qdata(qd2), .o_locked(lk2), .o_err_cnt(ec2), .o_state(st2)
  );

  int n_pass, n_total;
  logic chk_on, preset_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model of the 1-channel instance: collects whole periods and judges them as a unit.
  int          m_state, m_good, m_bad, m_n;
  logic [15:0] m_err;
  logic        m_vld, m_prev, m_per_good;
  logic [11:0] m_i, m_q;
  logic        r_fh [P1];
  logic        r_fl [P1];
  logic [5:0]  r_dh [P1];
  logic [5:0]  r_dl [P1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_good = 0; m_bad = 0; m_n = 0;
      m_err = '0; m_vld = 1'b0; m_prev = 1'b0; m_i = '0; m_q = '0;
    end else begin
      m_vld = 1'b0;
      if (m_state == 0 && fh && !m_prev) begin
        m_state = 1; m_good = 0; m_n = 0;
      end
      if (m_state != 0) begin
        r_fh[m_n] = fh; r_fl[m_n] = fl; r_dh[m_n] = dh; r_dl[m_n] = dl;
        m_n++;
        if (m_n == P1) begin
          m_n = 0;
          m_per_good = 1'b1;
          for (int k = 0; k < P1; k++) begin
            if ((r_fh[k] != (k < 1)) || (r_fl[k] != r_fh[k])) m_per_good = 1'b0;
          end
          if (!m_per_good && m_err != 16'hFFFF) m_err = m_err + 16'd1;
          if (m_state == 1) begin
            if (!m_per_good) m_state = 0;
            else begin
              m_good++;
              if (m_good == 4) begin m_state = 2; m_bad = 0; end
            end
          end else if (m_per_good) begin
            m_bad = 0; m_vld = 1'b1;
            m_i = {r_dl[0], r_dl[1]};
            m_q = {r_dh[0], r_dh[1]};
          end else begin
            m_bad++;
            if (m_bad == 3) begin m_state = 0; m_bad = 0; end
          end
        end
      end
      if (clr) m_err = '0;
      m_prev = fh;
      if (preset_req) begin
        force dut1.err_cnt_q = 16'hFFFD;
        m_err = 16'hFFFD;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("vld", {31'd0, vld1}, {31'd0, m_vld});
      chk("locked", {31'd0, lk1}, {31'd0, m_state == 2});
      chk("state", {30'd0, st1}, m_state);
      chk("err_cnt", {16'd0, ec1}, {16'd0, m_err});
      chk("idata", {20'd0, id1}, {20'd0, m_i});
      chk("qdata", {20'd0, qd1}, {20'd0, m_q});
    end
  end

  task automatic cyc(input logic f_h, input logic f_l, input logic [5:0] d_h,
                     input logic [5:0] d_l, input logic c);
    @(negedge clk);
    fh = f_h; fl = f_l; dh = d_h; dl = d_l; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic per1(input logic [11:0] iv, input logic [11:0] qv, input logic f0h,
                      input logic f0l, input logic f1h, input logic f1l,
                      input logic c0, input logic c1);
    cyc(f0h, f0l, qv[11:6], iv[11:6], c0);
    cyc(f1h, f1l, qv[5:0], iv[5:0], c1);
  endtask

  task automatic good1(input logic [11:0] iv, input logic [11:0] qv);
    per1(iv, qv, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc2(input logic f, input logic [5:0] d_h, input logic [5:0] d_l);
    @(negedge clk);
    f2 = f; d2h = d_h; d2l = d_l;
    @(posedge clk);
    #1;
  endtask

  // With cad set, checks the strobe lands only after the last phase of the period.
  task automatic per2(input logic [11:0] i0, input logic [11:0] q0, input logic [11:0] i1,
                      input logic [11:0] q1, input logic cad);
    cyc2(1'b1, q0[11:6], i0[11:6]);
    if (cad) chk("cad2_ph0", {31'd0, vld2}, 32'd0);
    cyc2(1'b1, q0[5:0], i0[5:0]);
    if (cad) chk("cad2_ph1", {31'd0, vld2}, 32'd0);
    cyc2(1'b0, q1[11:6], i1[11:6]);
    if (cad) chk("cad2_ph2", {31'd0, vld2}, 32'd0);
    cyc2(1'b0, q1[5:0], i1[5:0]);
    if (cad) chk("cad2_ph3", {31'd0, vld2}, 32'd1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; chk_on = 1'b0; preset_req = 1'b0;
    fh = 0; fl = 0; dh = '0; dl = '0; clr = 0;
    f2 = 0; d2h = '0; d2l = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_state", {30'd0, st1}, 32'd0);
    chk("rst_err", {16'd0, ec1}, 32'd0);
    chk("rst_idata2", {8'd0, id2}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // Two-channel instance
    for (int n = 1; n <= 4; n++) begin
      per2(12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
      if (n == 3) chk("lk2_p3", {31'd0, lk2}, 32'd0);
    end
    chk("lk2_p4", {31'd0, lk2}, 32'd1);
    chk("st2_p4", {30'd0, st2}, 32'd2);
    chk("vld2_p4", {31'd0, vld2}, 32'd0);
    per2(12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
    chk("vld2_p5", {31'd0, vld2}, 32'd1);
    chk("idata2_p5", {8'd0, id2}, 32'h333111);
    chk("qdata2_p5", {8'd0, qd2}, 32'h444222);
    per2(12'h0F0, 12'hA5A, 12'h5A5, 12'h00F, 1'b1);
    chk("idata2_p6", {8'd0, id2}, 32'h5A50F0);
    chk("qdata2_p6", {8'd0, qd2}, 32'h00FA5A);
    chk("err2", {16'd0, ec2}, 32'd0);
    cyc2(1'b0, 6'd0, 6'd0);

    // One-channel lock and data
    for (int n = 1; n <= 3; n++) good1(12'hABC, 12'h123);
    chk("lk1_p3", {31'd0, lk1}, 32'd0);
    chk("st1_p3", {30'd0, st1}, 32'd1);
    good1(12'hABC, 12'h123);
    chk("lk1_p4", {31'd0, lk1}, 32'd1);
    chk("vld1_p4", {31'd0, vld1}, 32'd0);
    good1(12'hABC, 12'h123);
    chk("vld1_p5", {31'd0, vld1}, 32'd1);
    chk("idata1_p5", {20'd0, id1}, 32'hABC);
    chk("qdata1_p5", {20'd0, qd1}, 32'h123);
    good1(12'hFC1, 12'h56A);
    chk("idata1_p6", {20'd0, id1}, 32'hFC1);
    chk("qdata1_p6", {20'd0, qd1}, 32'h56A);

    // FRAME halves disagree for one period
    per1(12'h777, 12'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_split", {16'd0, ec1}, 32'd1);
    chk("lk_split", {31'd0, lk1}, 32'd1);
    chk("vld_split", {31'd0, vld1}, 32'd0);
    chk("hold_split", {20'd0, id1}, 32'hFC1);
    good1(12'h246, 12'h9BD);
    chk("idata_after_split", {20'd0, id1}, 32'h246);

    // Loss of FRAME for three periods, then relock
    per1(12'h246, 12'h9BD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("err_clr", {16'd0, ec1}, 32'd0);
    for (int n = 0; n < 3; n++) per1(12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_unlock", {16'd0, ec1}, 32'd3);
    chk("st_unlock", {30'd0, st1}, 32'd0);
    chk("lk_unlock", {31'd0, lk1}, 32'd0);
    for (int n = 0; n < 3; n++) good1(12'h135, 12'h7E1);
    chk("lk_relock3", {31'd0, lk1}, 32'd0);
    good1(12'h135, 12'h7E1);
    chk("lk_relock4", {31'd0, lk1}, 32'd1);

    // Error counter saturation and clear priority
    preset_req = 1'b1;
    cyc(1'b1, 1'b1, 6'h01, 6'h02, 1'b0);
    release dut1.err_cnt_q;
    preset_req = 1'b0;
    cyc(1'b0, 1'b0, 6'h03, 6'h04, 1'b0);
    per1(12'h0AA, 12'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_fffe", {16'd0, ec1}, 32'hFFFE);
    per1(12'h0AA, 12'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_ffff", {16'd0, ec1}, 32'hFFFF);
    good1(12'h321, 12'h654);
    per1(12'h0AA, 12'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_sat", {16'd0, ec1}, 32'hFFFF);
    chk("lk_sat", {31'd0, lk1}, 32'd1);
    good1(12'h321, 12'h654);
    per1(12'h0AA, 12'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_clr_prio", {16'd0, ec1}, 32'd0);

    // Asynchronous reset mid-period while locked
    good1(12'h864, 12'h2C9);
    cyc(1'b1, 1'b1, 6'h11, 6'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, vld1}, 32'd0);
    chk("arst_lk", {31'd0, lk1}, 32'd0);
    chk("arst_st", {30'd0, st1}, 32'd0);
    chk("arst_id", {20'd0, id1}, 32'd0);
    chk("arst_qd", {20'd0, qd1}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    for (int n = 0; n < 4; n++) good1(12'h5F0, 12'h0A3);
    chk("rl_lk", {31'd0, lk1}, 32'd1);
    chk("rl_vld", {31'd0, vld1}, 32'd0);
    good1(12'h5F0, 12'h0A3);
    chk("rl_idata", {20'd0, id1}, 32'h5F0);
    chk("rl_qdata", {20'd0, qd1}, 32'h0A3);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ad80305_rx_deframer_mc.md
AD80305_RX_DEFRAMER_MC -- requirements
Module: ad80305_rx_deframer_mc

Interface
REQ-001 Parameter: LANE_W, 6, data bits per DDR beat; sample width SW = 2*LANE_W.
REQ-002 Parameter: NUM_CH, 1, receive channels, legal values 1 (1R1T) or 2 (2R2T); period P = 2*NUM_CH clocks.
REQ-003 Parameter: LOCK_PERIODS, 4, consecutive good periods required to lock, range 1..15.
REQ-004 Parameter: UNLOCK_ERRS, 3, consecutive bad periods that drop lock, range 1..15.
REQ-005 Port: i_rx_clk_p  in  1  DDR source clock; sole clock; all logic on its rising edge.
REQ-006 Port: i_fpga_rst_125p  in  1  reset, asynchronous, active-low.
REQ-007 Port: i_frame_h / i_frame_l  in  1 each  FRAME captured on the rising / falling edge.
REQ-008 Port: i_data_h / i_data_l  in  LANE_W each  rising-edge beat (Q half) / falling-edge beat (I half).
REQ-009 Port: i_err_clr  in  1  synchronous clear of o_err_cnt.
REQ-010 Port: o_iq_vld  out  1  one-cycle strobe; new sample set on o_idata/o_qdata.
REQ-011 Port: o_idata / o_qdata  out  NUM_CH*SW each  channel c occupies bits [c*SW +: SW].
REQ-012 Port: o_locked  out  1  high in LOCKED state.
REQ-013 Port: o_err_cnt  out  16  saturating count of bad periods.
REQ-014 Port: o_state  out  2  0=HUNT, 1=CHECK, 2=LOCKED.

Function
REQ-015 Phase counter p SHALL run 0..P-1 and wrap to 0; expected FRAME at phase p = (p < NUM_CH).
REQ-016 Phase p SHALL carry channel p>>1; p[0]=0 is the MSB half (bits SW-1:LANE_W), p[0]=1 the LSB half (bits LANE_W-1:0).
REQ-017 A cycle SHALL be mismatched if i_frame_h != i_frame_l or i_frame_h != expected FRAME.
REQ-018 A period SHALL be good only if all P cycles matched; otherwise bad.
REQ-019 HUNT: on i_frame_h=1 with registered previous i_frame_h=0, that cycle SHALL be phase 0, the good-period counter SHALL load 0, and the state SHALL go to CHECK.
REQ-020 CHECK: a good period SHALL increment the good counter; on the LOCK_PERIODS-th good period the state SHALL go to LOCKED at period end; a bad period SHALL return to HUNT.
REQ-021 LOCKED: a bad period SHALL increment the consecutive-bad counter and a good period SHALL clear it; reaching UNLOCK_ERRS SHALL go to HUNT.
REQ-022 In HUNT the phase counter SHALL hold 0 and no data SHALL be assembled.
REQ-023 Half-samples SHALL be staged in shadow registers; o_idata/o_qdata SHALL update, all channels at once, only on a good period completing in LOCKED, with o_iq_vld=1 the cycle after phase P-1.
REQ-024 On a bad period, or on the period that enters LOCKED, o_iq_vld SHALL stay 0 and outputs SHALL hold their previous values.
REQ-025 o_err_cnt SHALL increment once per bad period in CHECK or LOCKED and saturate at 0xFFFF.
REQ-026 i_err_clr SHALL zero o_err_cnt; it SHALL take priority over a simultaneous increment.
REQ-027 Sustained throughput SHALL be one o_iq_vld per P clocks with no gaps while good periods continue.

Reset
REQ-028 Reset low SHALL asynchronously force state HUNT, all counters 0, o_iq_vld=0, o_idata=0, o_qdata=0, o_locked=0, o_err_cnt=0, o_state=0.
REQ-029 Reset asserted mid-period SHALL discard any partial sample; after release, lock SHALL be reacquired from HUNT.

Verification
REQ-030 NUM_CH=1: per period drive FRAME 1 with h=0x04, l=0x2A, then FRAME 0 with h=0x23, l=0x3C -> o_locked high after period 4; first o_iq_vld in period 5 with o_idata=0xABC, o_qdata=0x123; then one strobe every 2 clocks.
REQ-031 NUM_CH=2: FRAME 1,1,0,0 carrying ch0 I=0x111/Q=0x222 and ch1 I=0x333/Q=0x444 -> o_idata=0x333111, o_qdata=0x444222, strobe every 4 clocks.
REQ-032 Locked, with one period where i_frame_l != i_frame_h -> no strobe for that period, o_err_cnt=1, o_locked stays 1.
REQ-033 Locked, with FRAME held 0 for 3 periods -> o_err_cnt=3, o_state=0, o_locked=0; restoring the pattern relocks after 4 good periods.
REQ-034 o_err_cnt preset to 0xFFFF by bad periods: further bad periods hold 0xFFFF; i_err_clr asserted in the same cycle as an increment gives 0.
REQ-035 Reset pulse mid-period while locked -> all outputs 0 immediately; no strobe until relock.
